// File: rtl/data_mmio_bridge.sv
// data_mmio_bridge: routes core data requests to RAM, a console/cycle/exit MMIO block, or unmapped space.
module data_mmio_bridge #(
  parameter int          ADDR_WIDTH  = 24,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [63:0] CYCLE_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  ram_req_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic                  ram_gnt_i,
  input  logic                  ram_rvalid_i,
  input  logic [31:0]           ram_rdata_i,
  output logic                  cons_valid_o,
  output logic [7:0]            cons_data_o,
  input  logic                  cons_ready_i,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_code_o,
  output logic                  bus_err_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic ram_hit, mmio_hit, full, stall, int_gnt, push, pop, resp_ram, int_rvalid;
  logic [2:0] off;
  logic [31:0] int_rdata, rd_val, shadow;
  logic [63:0] cycle;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  assign ram_hit = data_addr_i[31:ADDR_WIDTH] == '0;
  assign mmio_hit = data_addr_i[31:5] == MMIO_BASE[31:5];
  assign off = data_addr_i[4:2];
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign stall = mmio_hit & data_we_i & (off == 3'd0) & full;
  assign int_gnt = data_req_i & ~ram_hit & ~stall;
  assign ram_req_o = data_req_i & ram_hit;
  assign ram_addr_o = data_addr_i[ADDR_WIDTH-1:0];
  assign ram_we_o = data_we_i;
  assign ram_be_o = data_be_i;
  assign ram_wdata_o = data_wdata_i;
  assign data_gnt_o = ram_hit ? ram_req_o & ram_gnt_i : int_gnt;
  assign data_rvalid_o = resp_ram ? ram_rvalid_i : int_rvalid;
  assign data_rdata_o = resp_ram ? ram_rdata_i : int_rdata;
  assign push = int_gnt & mmio_hit & data_we_i & (off == 3'd0) & data_be_i[0];
  assign pop = cons_valid_o & cons_ready_i;
  assign cons_valid_o = count != '0;
  assign cons_data_o = cons_valid_o ? fifo[rp] : '0;
  always_comb begin
    rd_val = '0;
    if (mmio_hit)
      rd_val = off == 3'd1 ? {16'b0, 8'(FIFO_DEPTH) - 8'(count), 8'(count)} :
               off == 3'd2 ? cycle[31:0] :
               off == 3'd3 ? shadow : '0;
  end
  always_ff @(posedge clk)
    if (push) fifo[wp] <= data_wdata_i[7:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_ram <= 1'b0;
      int_rvalid <= 1'b0;
      int_rdata <= '0;
      shadow <= '0;
      cycle <= CYCLE_RESET;
      wp <= '0;
      rp <= '0;
      count <= '0;
      exit_valid_o <= 1'b0;
      exit_code_o <= '0;
      bus_err_o <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      int_rvalid <= int_gnt;
      if (data_gnt_o) resp_ram <= ram_hit;
      if (int_gnt) int_rdata <= data_we_i ? '0 : rd_val;
      // reading CYCLE_LO freezes the upper half so a following CYCLE_HI read is coherent
      if (int_gnt & mmio_hit & ~data_we_i & (off == 3'd2)) shadow <= cycle[63:32];
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (int_gnt & mmio_hit & data_we_i & (off == 3'd4) & ~exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_code_o <= data_wdata_i;
      end
      if (int_gnt & ~mmio_hit) bus_err_o <= 1'b1;
    end
  end
endmodule
